// File: rtl/rv_go_pkg.sv
// Shared constants for the rv_go load/store path: funct3 access codes and LSU state encoding.
package rv_go_pkg;

    localparam logic [2:0] MEM_LB  = 3'b000;
    localparam logic [2:0] MEM_LH  = 3'b001;
    localparam logic [2:0] MEM_LW  = 3'b010;
    localparam logic [2:0] MEM_LBU = 3'b100;
    localparam logic [2:0] MEM_LHU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/rv_go_lsu_if.sv
// Word-aligned request/grant/rvalid data bus between the LSU (master) and data RAM (slave).
interface rv_go_lsu_if;

    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/rv_go_lsu_align.sv
// Access legality, byte enables, store lane replication and load lane extraction/extension.
module rv_go_lsu_align
    import rv_go_pkg::*;
(
    input  logic [2:0]  mem_op_i,
    input  logic        mem_w_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] bus_rdata_i,
    output logic        legal_o,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        legal_o = 1'b0;
        be_o    = 4'b0000;
        wdata_o = 32'h0;
        case (mem_op_i)
            MEM_LB, MEM_LBU: begin
                legal_o = !(mem_w_i && (mem_op_i == MEM_LBU));
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            MEM_LH, MEM_LHU: begin
                legal_o = !addr_lo_i[0] && !(mem_w_i && (mem_op_i == MEM_LHU));
                be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
            end
            MEM_LW: begin
                legal_o = (addr_lo_i == 2'b00);
                be_o    = 4'b1111;
                wdata_o = wdata_i;
            end
            default: ;
        endcase
    end

    always_comb begin
        lane_b = bus_rdata_i[7:0];
        case (addr_lo_i)
            2'd1:    lane_b = bus_rdata_i[15:8];
            2'd2:    lane_b = bus_rdata_i[23:16];
            2'd3:    lane_b = bus_rdata_i[31:24];
            default: lane_b = bus_rdata_i[7:0];
        endcase
        lane_h = addr_lo_i[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];

        rdata_o = 32'h0;
        case (mem_op_i)
            MEM_LB:  rdata_o = {{24{lane_b[7]}}, lane_b};
            MEM_LBU: rdata_o = {24'h0, lane_b};
            MEM_LH:  rdata_o = {{16{lane_h[15]}}, lane_h};
            MEM_LHU: rdata_o = {16'h0, lane_h};
            MEM_LW:  rdata_o = bus_rdata_i;
            default: rdata_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/rv_go_lsu.sv
// Load/store unit: takes one core access, runs it on the data bus, returns extended load data.
// state | meaning:  IDLE ready | REQ bus_req held for gnt | WAIT load awaits rvalid | RESP one-cycle response
module rv_go_lsu
    import rv_go_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        mem_w_i,
    input  logic [2:0]  mem_op_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    rv_go_lsu_if.master bus
);

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    lsu_state_e  state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [1:0]  alo_q, alo_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]  bus_be_q, bus_be_d;

    logic        idle;
    logic [2:0]  al_op;
    logic [1:0]  al_alo;
    logic        al_w;
    logic        al_legal;
    logic [3:0]  al_be;
    logic [31:0] al_wdata, al_rdata;
    logic [7:0]  cnt_inc;
    logic        timeout;

    // The aligner sees the live request while IDLE and the latched access afterwards.
    assign idle    = (state_q == ST_IDLE);
    assign al_op   = idle ? mem_op_i    : op_q;
    assign al_alo  = idle ? addr_i[1:0] : alo_q;
    assign al_w    = idle ? mem_w_i     : bus_we_q;
    assign cnt_inc = cnt_q + 8'd1;
    assign timeout = (cnt_inc == WAIT_LIMIT);

    rv_go_lsu_align u_align (
        .mem_op_i    (al_op),
        .mem_w_i     (al_w),
        .addr_lo_i   (al_alo),
        .wdata_i     (wdata_i),
        .bus_rdata_i (bus.rdata),
        .legal_o     (al_legal),
        .be_o        (al_be),
        .wdata_o     (al_wdata),
        .rdata_o     (al_rdata)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            op_q         <= 3'b000;
            alo_q        <= 2'b00;
            cnt_q        <= 8'h00;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= 32'h0;
            bus_wdata_q  <= 32'h0;
            bus_be_q     <= 4'b0000;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            alo_q        <= alo_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            bus_be_q     <= bus_be_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        alo_d        = alo_q;
        cnt_d        = cnt_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'h0;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        bus_be_d     = bus_be_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    op_d  = mem_op_i;
                    alo_d = addr_i[1:0];
                    cnt_d = 8'h00;
                    if (al_legal) begin
                        state_d     = ST_REQ;
                        bus_req_d   = 1'b1;
                        bus_we_d    = mem_w_i;
                        bus_addr_d  = {addr_i[31:2], 2'b00};
                        bus_be_d    = al_be;
                        bus_wdata_d = al_wdata;
                    end else begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                // A grant in the timeout cycle still completes the access.
                if (bus.gnt) begin
                    bus_req_d = 1'b0;
                    cnt_d     = 8'h00;
                    if (bus_we_q) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else if (timeout) begin
                    bus_req_d    = 1'b0;
                    cnt_d        = cnt_inc;
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_WAIT: begin
                if (bus.rvalid) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = al_rdata;
                end else if (timeout) begin
                    cnt_d        = cnt_inc;
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign req_ready_o  = idle;
    assign resp_valid_o = resp_valid_q;
    assign resp_err_o   = resp_err_q;
    assign resp_rdata_o = resp_rdata_q;
    assign bus.req      = bus_req_q;
    assign bus.we       = bus_we_q;
    assign bus.addr     = bus_addr_q;
    assign bus.be       = bus_be_q;
    assign bus.wdata    = bus_wdata_q;

endmodule
